// File: rtl/traffic_light_monitor.sv
// Passive safety observer for a two-direction traffic light controller.
// Flags lamp encoding, right-of-way conflict, phase-order and phase-duration violations.
module traffic_light_monitor #(
  parameter int MIN_GREEN     = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ns_light,
  input  logic [2:0]  ew_light,
  input  logic        clear,
  output logic        err_encoding,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timing,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] round_count
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] YEL_C     = CNT_W'(YELLOW_CYCLES);

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ENCODING = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE = 3'd3;
  localparam logic [2:0] CODE_TIMING   = 3'd4;

  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

  state_t      state_reg, state_next;
  logic        checking;

  logic [1:0]  legal_v;
  logic [1:0]  seq_v;
  logic [1:0]  tim_v;
  logic [2:0]  ns_prev;

  logic        enc_hit, conf_hit, seq_hit, tim_hit, any_hit, ns_round;
  logic [2:0]  hit_code;

  logic        err_encoding_reg, err_conflict_reg, err_sequence_reg, err_timing_reg;
  logic        fault_reg, fault_next;
  logic [2:0]  fault_code_reg, fault_code_next;
  logic [15:0] round_count_reg, round_count_next;

  // Sequence and timing checks are suppressed only on the baseline cycle.
  assign checking = (state_reg != INIT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      logic [2:0]       lamp;
      logic [2:0]       prev_reg, prev_next;
      logic [CNT_W-1:0] dwell_reg, dwell_next;
      logic             is_legal, seq_bad, tim_bad;

      assign lamp     = (gi == 0) ? ns_light : ew_light;
      assign is_legal = (lamp == RED) || (lamp == YEL) || (lamp == GRN);

      // Illegal samples leave prev/dwell untouched and skip phase checks.
      always_comb begin
        prev_next  = prev_reg;
        dwell_next = dwell_reg;
        seq_bad    = 1'b0;
        tim_bad    = 1'b0;
        if (is_legal) begin
          if (!checking) begin
            prev_next  = lamp;
            dwell_next = DWELL_ONE;
          end else if (lamp == prev_reg) begin
            if (dwell_reg != DWELL_MAX) begin
              dwell_next = dwell_reg + DWELL_ONE;
            end
          end else begin
            prev_next  = lamp;
            dwell_next = DWELL_ONE;
            case (prev_reg)
              GRN: begin
                if (lamp != YEL) begin
                  seq_bad = 1'b1;
                end else if ((dwell_reg != DWELL_MAX) && (dwell_reg < MIN_G)) begin
                  tim_bad = 1'b1;
                end
              end
              YEL: begin
                if (lamp != RED) begin
                  seq_bad = 1'b1;
                end else if (dwell_reg != YEL_C) begin
                  tim_bad = 1'b1;
                end
              end
              default: begin
                if (lamp != GRN) begin
                  seq_bad = 1'b1;
                end
              end
            endcase
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prev_reg  <= RED;
          dwell_reg <= '0;
        end else begin
          prev_reg  <= prev_next;
          dwell_reg <= dwell_next;
        end
      end

      assign legal_v[gi] = is_legal;
      assign seq_v[gi]   = seq_bad;
      assign tim_v[gi]   = tim_bad;

      if (gi == 0) begin : g_ns
        assign ns_prev = prev_reg;
      end
    end
  endgenerate

  assign enc_hit  = ~&legal_v;
  assign conf_hit = (&legal_v) && (ns_light != RED) && (ew_light != RED);
  assign seq_hit  = |seq_v;
  assign tim_hit  = |tim_v;
  assign any_hit  = enc_hit || conf_hit || seq_hit || tim_hit;
  assign ns_round = checking && (ns_prev == RED) && (ns_light == GRN);

  always_comb begin
    hit_code = CODE_NONE;
    if (enc_hit) begin
      hit_code = CODE_ENCODING;
    end else if (conf_hit) begin
      hit_code = CODE_CONFLICT;
    end else if (seq_hit) begin
      hit_code = CODE_SEQUENCE;
    end else if (tim_hit) begin
      hit_code = CODE_TIMING;
    end
  end

  // A clear on the same edge as an error still lets the pulses out but keeps the sticky fault low.
  always_comb begin
    state_next       = state_reg;
    fault_next       = fault_reg | any_hit;
    fault_code_next  = fault_code_reg;
    round_count_next = round_count_reg;
    if (!fault_reg && any_hit) begin
      fault_code_next = hit_code;
    end
    if (ns_round) begin
      round_count_next = round_count_reg + 16'd1;
    end
    case (state_reg)
      INIT:    state_next = any_hit ? FAULT : RUN;
      RUN:     state_next = any_hit ? FAULT : RUN;
      FAULT:   state_next = FAULT;
      default: state_next = INIT;
    endcase
    if (clear) begin
      state_next      = INIT;
      fault_next      = 1'b0;
      fault_code_next = CODE_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= INIT;
      err_encoding_reg <= 1'b0;
      err_conflict_reg <= 1'b0;
      err_sequence_reg <= 1'b0;
      err_timing_reg   <= 1'b0;
      fault_reg        <= 1'b0;
      fault_code_reg   <= CODE_NONE;
      round_count_reg  <= 16'd0;
    end else begin
      state_reg        <= state_next;
      err_encoding_reg <= enc_hit;
      err_conflict_reg <= conf_hit;
      err_sequence_reg <= seq_hit;
      err_timing_reg   <= tim_hit;
      fault_reg        <= fault_next;
      fault_code_reg   <= fault_code_next;
      round_count_reg  <= round_count_next;
    end
  end

  assign err_encoding = err_encoding_reg;
  assign err_conflict = err_conflict_reg;
  assign err_sequence = err_sequence_reg;
  assign err_timing   = err_timing_reg;
  assign fault        = fault_reg;
  assign fault_code   = fault_code_reg;
  assign round_count  = round_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized controller traffic,
// checked every cycle against a phase-index reference model.
module tb_traffic_light_monitor;

  localparam int MIN_G = 4;
  localparam int YEL_C = 2;
  localparam int DMAX  = 255;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  ns_light = 3'b100;
  logic [2:0]  ew_light = 3'b100;
  logic        clear = 1'b0;
  logic        err_encoding, err_conflict, err_sequence, err_timing, fault;
  logic [2:0]  fault_code;
  logic [15:0] round_count;

  int checks = 0;
  int errors = 0;

  traffic_light_monitor #(
    .MIN_GREEN(MIN_G),
    .YELLOW_CYCLES(YEL_C),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .clear(clear),
    .err_encoding(err_encoding),
    .err_conflict(err_conflict),
    .err_sequence(err_sequence),
    .err_timing(err_timing),
    .fault(fault),
    .fault_code(fault_code),
    .round_count(round_count)
  );

  always #5 clk = ~clk;

  // Reference model: lamps as phase indices 0=red, 1=green, 2=yellow; a legal change is +1 mod 3.
  int          m_phase[2];
  int          m_dwell[2];
  bit          m_base;
  bit          e_enc, e_conf, e_seq, e_tim, e_fault;
  int          e_code;
  int          e_rounds;

  function automatic int phase_of(input logic [2:0] v);
    if (v == R) return 0;
    if (v == G) return 1;
    if (v == Y) return 2;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_dwell[d] = 0;
    end
    m_base = 1'b1;
    e_enc = 0; e_conf = 0; e_seq = 0; e_tim = 0; e_fault = 0;
    e_code = 0;
    e_rounds = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] ns, input logic [2:0] ew, input bit clr);
    int ph[2];
    bit enc, conf, seq, tim;
    ph[0] = phase_of(ns);
    ph[1] = phase_of(ew);
    enc = 0; seq = 0; tim = 0;
    for (int d = 0; d < 2; d++) begin
      if (ph[d] < 0) begin
        enc = 1;
      end else if (m_base) begin
        m_phase[d] = ph[d];
        m_dwell[d] = 1;
      end else if (ph[d] == m_phase[d]) begin
        m_dwell[d] = (m_dwell[d] + 1 > DMAX) ? DMAX : m_dwell[d] + 1;
      end else begin
        if (ph[d] != (m_phase[d] + 1) % 3) begin
          seq = 1;
        end else begin
          if (ph[d] == 2 && m_dwell[d] < MIN_G && m_dwell[d] != DMAX) tim = 1;
          if (ph[d] == 0 && m_dwell[d] != YEL_C) tim = 1;
          if (ph[d] == 1 && d == 0) e_rounds = (e_rounds + 1) % 65536;
        end
        m_phase[d] = ph[d];
        m_dwell[d] = 1;
      end
    end
    conf = (ph[0] > 0) && (ph[1] > 0);
    e_enc = enc; e_conf = conf; e_seq = seq; e_tim = tim;
    if (clr) begin
      e_fault = 0;
      e_code = 0;
    end else if ((enc || conf || seq || tim) && !e_fault) begin
      e_fault = 1;
      e_code = enc ? 1 : conf ? 2 : seq ? 3 : 4;
    end
    m_base = clr;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge(ns_light, ew_light, clear);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("err_encoding", 32'(err_encoding), 32'(e_enc));
      chk("err_conflict", 32'(err_conflict), 32'(e_conf));
      chk("err_sequence", 32'(err_sequence), 32'(e_seq));
      chk("err_timing", 32'(err_timing), 32'(e_tim));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("fault_code", 32'(fault_code), 32'(e_code));
      chk("round_count", 32'(round_count), 32'(e_rounds));
    end
  end

  // Present one sample; returns 2 ns after the edge that consumed it.
  task automatic sample(input logic [2:0] ns, input logic [2:0] ew, input bit clr = 1'b0);
    ns_light = ns;
    ew_light = ew;
    clear = clr;
    @(posedge clk);
    #2;
    clear = 1'b0;
  endtask

  task automatic legal_round();
    repeat (MIN_G) sample(G, R);
    repeat (YEL_C) sample(Y, R);
    repeat (MIN_G) sample(R, G);
    repeat (YEL_C) sample(R, Y);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_enc"}, 32'(err_encoding), 0);
    chk({tag, "_conf"}, 32'(err_conflict), 0);
    chk({tag, "_seq"}, 32'(err_sequence), 0);
    chk({tag, "_tim"}, 32'(err_timing), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_code"}, 32'(fault_code), 0);
    chk({tag, "_rounds"}, 32'(round_count), 0);
  endtask

  task automatic rnd_phase(input logic [2:0] ns, input logic [2:0] ew, input int n);
    logic [2:0] a, b;
    bit c;
    for (int i = 0; i < n; i++) begin
      a = ns;
      b = ew;
      c = 1'b0;
      if ($urandom_range(0, 24) == 0) a = 3'($urandom);
      if ($urandom_range(0, 24) == 0) b = 3'($urandom);
      if ($urandom_range(0, 59) == 0) c = 1'b1;
      sample(a, b, c);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    all_zero("reset");
    reset = 1'b0;

    // Three legal rounds
    sample(R, R);
    repeat (3) legal_round();
    sample(R, R);
    chk("legal_rounds", 32'(round_count), 3);
    chk("legal_fault", 32'(fault), 0);

    // Short green
    repeat (3) sample(G, R);
    sample(Y, R);
    chk("short_green_tim", 32'(err_timing), 1);
    chk("short_green_fault", 32'(fault), 1);
    chk("short_green_code", 32'(fault_code), 4);
    sample(Y, R);
    sample(R, R, 1'b1);
    chk("clear1_fault", 32'(fault), 0);
    sample(R, R);

    // Bad encoding with would-be conflict, then real conflict
    sample(G, 3'b011);
    chk("enc_enc", 32'(err_encoding), 1);
    chk("enc_conf", 32'(err_conflict), 0);
    chk("enc_code", 32'(fault_code), 1);
    sample(G, G);
    chk("conf_conf", 32'(err_conflict), 1);
    chk("conf_code", 32'(fault_code), 1);
    sample(R, R, 1'b1);
    chk("clear2_fault", 32'(fault), 0);
    sample(R, R);

    // Sequence skip, clear, then clean round
    repeat (4) sample(G, R);
    sample(R, R);
    chk("skip_seq", 32'(err_sequence), 1);
    chk("skip_code", 32'(fault_code), 3);
    sample(R, R, 1'b1);
    chk("clear3_fault", 32'(fault), 0);
    chk("clear3_code", 32'(fault_code), 0);
    sample(R, R);
    legal_round();
    sample(R, R);
    chk("after_clear_fault", 32'(fault), 0);

    // Yellow too long
    repeat (4) sample(G, R);
    repeat (3) sample(Y, R);
    chk("long_yel_early", 32'(err_timing), 0);
    sample(R, R);
    chk("long_yel_tim", 32'(err_timing), 1);
    chk("long_yel_code", 32'(fault_code), 4);
    sample(R, R, 1'b1);
    sample(R, R);

    // Saturated green dwell still satisfies the minimum
    repeat (300) sample(G, R);
    repeat (2) sample(Y, R);
    sample(R, R);
    chk("sat_fault", 32'(fault), 0);

    // Reset during NS yellow, release while the lights carry on
    repeat (4) sample(G, R);
    sample(Y, R);
    reset = 1'b1;
    #1;
    all_zero("midreset");
    sample(Y, R);
    reset = 1'b0;
    sample(R, G);
    repeat (3) sample(R, G);
    repeat (2) sample(R, Y);
    sample(G, R);
    chk("postreset_rounds", 32'(round_count), 1);
    chk("postreset_fault", 32'(fault), 0);

    // Randomized controller traffic with glitches and occasional clears
    for (int r = 0; r < 220; r++) begin
      rnd_phase(G, R, $urandom_range(3, 6));
      rnd_phase(Y, R, $urandom_range(1, 3));
      rnd_phase(R, R, $urandom_range(0, 1));
      rnd_phase(R, G, $urandom_range(3, 6));
      rnd_phase(R, Y, $urandom_range(1, 3));
    end
    sample(R, R);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
